// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front end.
// Tracks bit/edge position and majority-votes three samples per bit.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  frame_done
);

  typedef logic [PRESCALE_W-1:0] pre_t;
  typedef logic [BIT_CNT_W-1:0]  bit_t;

  pre_t p_eff;
  pre_t half;
  bit_t last_bit;
  logic wrap;
  logic last;
  logic at_s0;
  logic at_s1;
  logic at_s2;
  logic vote;
  logic s0;
  logic s1;

  // Unsupported ratios fall back to 8x.
  always_comb begin
    p_eff = pre_t'(8);
    unique case (1'b1)
      (prescale == pre_t'(16)): p_eff = pre_t'(16);
      (prescale == pre_t'(32)): p_eff = pre_t'(32);
      default:                  p_eff = pre_t'(8);
    endcase
  end

  assign half     = p_eff >> 1;
  assign last_bit = par_en ? bit_t'(10) : bit_t'(9);
  assign wrap     = edge_cnt == p_eff - pre_t'(1);
  assign last     = bit_cnt == last_bit;
  assign at_s0    = edge_cnt == half - pre_t'(2);
  assign at_s1    = edge_cnt == half - pre_t'(1);
  assign at_s2    = edge_cnt == half;

  // Third sample is taken live so the vote lands one cycle after centre.
  assign vote = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else if (!enable) begin
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sample_valid <= at_s2;
      frame_done   <= wrap & last;
      if (at_s0) s0 <= rx_in;
      if (at_s1) s1 <= rx_in;
      if (at_s2) sampled_bit <= vote;
      if (wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= last ? '0 : bit_cnt + bit_t'(1);
      end else begin
        edge_cnt <= edge_cnt + pre_t'(1);
      end
    end
  end

endmodule
